// File: rtl/mem_ctrl.sv
// Burst memory controller that drives the 512x32 single-port ram block.
// Reads assume one clock of RAM latency; writes pass beat data straight through to the RAM.
module mem_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              done,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      RD_RUN,
      RD_DRAIN,
      WR_RUN,
      DONE
   } state_t;

   localparam logic [LEN_W:0] LAST_WORD = {{LEN_W{1'b0}}, 1'b1};

   state_t            state;
   state_t            nextState;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W:0]    remaining;
   logic [1:0]        cap_pipe;
   logic              issue;
   logic              beat;

   // State register; clear abandons any burst in flight without a done pulse.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and RAM strobes; strobes only leave zero while a read issues or a write beat lands.
   always_comb begin
      nextState   = state;
      busy        = (state != IDLE);
      issue       = 1'b0;
      beat        = 1'b0;
      wdata_ready = 1'b0;
      done        = 1'b0;
      ram_read    = 1'b0;
      ram_write   = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      case (state)
         IDLE: begin
            if (req) begin
               nextState = we ? WR_RUN : RD_RUN;
            end
         end
         RD_RUN: begin
            issue    = 1'b1;
            ram_read = 1'b1;
            ram_addr = cur_addr;
            if (remaining == LAST_WORD) begin
               nextState = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (!cap_pipe[0]) begin
               nextState = DONE;
            end
         end
         WR_RUN: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               beat      = 1'b1;
               ram_write = 1'b1;
               ram_addr  = cur_addr;
               ram_wdata = wdata;
               if (remaining == LAST_WORD) begin
                  nextState = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Burst address and word counter; the address wraps naturally at 2^ADDR_W.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         cur_addr  <= '0;
         remaining <= '0;
      end else if (state == IDLE && req) begin
         cur_addr  <= start_addr;
         remaining <= {1'b0, len} + LAST_WORD;
      end else if (issue || beat) begin
         cur_addr  <= cur_addr + ADDR_W'(1);
         remaining <= remaining - LAST_WORD;
      end
   end

   // cap_pipe[0] marks the cycle the RAM presents an issued word; cap_pipe[1] marks rdata holding it.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         cap_pipe <= '0;
         rdata    <= '0;
      end else begin
         cap_pipe <= {cap_pipe[0], issue};
         if (cap_pipe[0]) begin
            rdata <= ram_rdata;
         end
      end
   end

   assign rdata_valid = cap_pipe[1];

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a behavioural RAM plus a cycle-timed burst model.
// A table of directed bursts runs first, then randomized bursts against the same model.
module tb_mem_ctrl;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;
   localparam int DEPTH  = 512;

   logic              clock = 1'b0;
   logic              clear;
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic [DATA_W-1:0] wdata;
   logic              wdata_valid;
   logic              wdata_ready;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;
   logic              done;
   logic              ram_read;
   logic              ram_write;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata = '0;

   int vectors     = 0;
   int miscompares = 0;

   logic [DATA_W-1:0] ramMem [DEPTH];
   logic [DATA_W-1:0] refMem [DEPTH];

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [31:0]       mask;
      logic [DATA_W-1:0] dataBase;
      logic              busyReq;
      int                expDone;
   } burst_t;

   burst_t vecTable [8];
   burst_t rnd;

   mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clock       (clock),
      .clear       (clear),
      .req         (req),
      .we          (we),
      .start_addr  (start_addr),
      .len         (len),
      .busy        (busy),
      .wdata       (wdata),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .done        (done),
      .ram_read    (ram_read),
      .ram_write   (ram_write),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   always #5 clock = ~clock;

   // Environment RAM with one clock of registered read latency.
   always @(posedge clock) begin
      if (ram_write) ramMem[ram_addr] <= ram_wdata;
      if (ram_read) ram_rdata <= ramMem[ram_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one burst; cycle 0 is the cycle req is presented, outputs are sampled at each negedge.
   task automatic applyStimulus(input burst_t b);
      int lenWords, beats, lastBeat, doneSeen, addrI;
      bit finished, offered, inRun;
      bit expRead, expWrite, expValid, expDone, expBusy, expReady;
      logic [31:0] expAddr, expWdata, beatData;
      lenWords = int'(b.len) + 1;
      addrI    = int'(b.addr);
      beats    = 0;
      lastBeat = -10;
      doneSeen = -1;
      finished = 1'b0;
      @(posedge clock); #1;
      req = 1'b1; we = b.we; start_addr = b.addr; len = b.len; wdata_valid = 1'b0;
      @(negedge clock);
      checkOutput("busyBeforeAccept", 32'(busy), 32'd0);
      for (int c = 1; c <= 64 && !finished; c++) begin
         @(posedge clock); #1;
         req = b.busyReq && (c == 2);
         if (req) begin
            we = 1'b1;
            start_addr = ADDR_W'($urandom);
            len = LEN_W'($urandom);
         end
         inRun    = b.we && (beats < lenWords);
         offered  = b.we ? (inRun && ((c > 32) ? 1'b1 : b.mask[c-1])) : 1'($urandom_range(0, 1));
         beatData = b.dataBase + 32'(beats);
         wdata_valid = offered;
         wdata = offered ? beatData : 32'($urandom);
         @(negedge clock);
         if (b.we) begin
            expRead  = 1'b0;
            expValid = 1'b0;
            expReady = inRun;
            expWrite = inRun && offered;
            expAddr  = expWrite ? 32'((addrI + beats) % DEPTH) : 32'd0;
            expWdata = expWrite ? beatData : 32'd0;
            expDone  = !inRun && (c == lastBeat + 1);
            expBusy  = inRun || expDone;
            if (expWrite) begin
               refMem[(addrI + beats) % DEPTH] = beatData;
               beats++;
               lastBeat = c;
            end
            finished = !inRun && (c == lastBeat + 2);
         end else begin
            expRead  = (c <= lenWords);
            expWrite = 1'b0;
            expReady = 1'b0;
            expWdata = 32'd0;
            expAddr  = expRead ? 32'((addrI + c - 1) % DEPTH) : 32'd0;
            expValid = (c >= 3) && (c <= lenWords + 2);
            expDone  = (c == lenWords + 3);
            expBusy  = (c <= lenWords + 3);
            if (expValid) checkOutput("rdata", rdata, refMem[(addrI + c - 3) % DEPTH]);
            if (c == lenWords + 4) begin
               checkOutput("rdataHold", rdata, refMem[(addrI + lenWords - 1) % DEPTH]);
               finished = 1'b1;
            end
         end
         checkOutput("ramRead", 32'(ram_read), 32'(expRead));
         checkOutput("ramWrite", 32'(ram_write), 32'(expWrite));
         checkOutput("ramAddr", 32'(ram_addr), expAddr);
         checkOutput("ramWdata", ram_wdata, expWdata);
         checkOutput("rdataValid", 32'(rdata_valid), 32'(expValid));
         checkOutput("done", 32'(done), 32'(expDone));
         checkOutput("busy", 32'(busy), 32'(expBusy));
         checkOutput("wdataReady", 32'(wdata_ready), 32'(expReady));
         if (done === 1'b1 && doneSeen < 0) doneSeen = c;
      end
      req = 1'b0;
      wdata_valid = 1'b0;
      checkOutput("burstFinished", 32'(finished), 32'd1);
      if (b.expDone > 0) checkOutput("doneCycle", 32'(doneSeen), 32'(b.expDone));
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ramMem[i] = 32'(i + 100);
         refMem[i] = 32'(i + 100);
      end

      vecTable[0] = '{we: 1'b0, addr: 9'h000, len: 4'd15, mask: 32'hFFFF_FFFF, dataBase: 32'h0,         busyReq: 1'b0, expDone: 19};
      vecTable[1] = '{we: 1'b1, addr: 9'h005, len: 4'd0,  mask: 32'hFFFF_FFFF, dataBase: 32'hDEADBEEF, busyReq: 1'b0, expDone: 2};
      vecTable[2] = '{we: 1'b0, addr: 9'h005, len: 4'd0,  mask: 32'hFFFF_FFFF, dataBase: 32'h0,         busyReq: 1'b0, expDone: 4};
      vecTable[3] = '{we: 1'b1, addr: 9'h1FE, len: 4'd3,  mask: 32'hFFFF_FFFF, dataBase: 32'h1,         busyReq: 1'b0, expDone: 5};
      vecTable[4] = '{we: 1'b0, addr: 9'h1FE, len: 4'd3,  mask: 32'hFFFF_FFFF, dataBase: 32'h0,         busyReq: 1'b0, expDone: 7};
      vecTable[5] = '{we: 1'b1, addr: 9'h028, len: 4'd2,  mask: 32'h0000_0049, dataBase: 32'h5000,      busyReq: 1'b0, expDone: 8};
      vecTable[6] = '{we: 1'b0, addr: 9'h028, len: 4'd2,  mask: 32'hFFFF_FFFF, dataBase: 32'h0,         busyReq: 1'b1, expDone: 6};
      vecTable[7] = '{we: 1'b0, addr: 9'h1F0, len: 4'd15, mask: 32'hFFFF_FFFF, dataBase: 32'h0,         busyReq: 1'b0, expDone: 19};

      clear = 1'b1; req = 1'b0; we = 1'b0; start_addr = '0; len = '0;
      wdata = '0; wdata_valid = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstRamRead", 32'(ram_read), 32'd0);
      checkOutput("rstRamWrite", 32'(ram_write), 32'd0);
      checkOutput("rstRamAddr", 32'(ram_addr), 32'd0);
      checkOutput("rstRamWdata", ram_wdata, 32'd0);
      checkOutput("rstRdata", rdata, 32'd0);
      checkOutput("rstRdataValid", 32'(rdata_valid), 32'd0);
      checkOutput("rstWdataReady", 32'(wdata_ready), 32'd0);
      @(posedge clock); #1;
      clear = 1'b0;

      for (int i = 0; i < 8; i++) applyStimulus(vecTable[i]);

      // Clear in cycle 2 of a 4-word write: only the first beat may reach the RAM.
      @(posedge clock); #1;
      req = 1'b1; we = 1'b1; start_addr = 9'd20; len = 4'd3; wdata_valid = 1'b0;
      @(posedge clock); #1;
      req = 1'b0; wdata_valid = 1'b1; wdata = 32'hAAAA_0001;
      @(negedge clock);
      checkOutput("clrBeat1Write", 32'(ram_write), 32'd1);
      checkOutput("clrBeat1Addr", 32'(ram_addr), 32'd20);
      refMem[20] = 32'hAAAA_0001;
      @(posedge clock); #1;
      wdata = 32'hAAAA_0002; clear = 1'b1;
      #1;
      checkOutput("clrRamWrite", 32'(ram_write), 32'd0);
      checkOutput("clrBusy", 32'(busy), 32'd0);
      checkOutput("clrDone", 32'(done), 32'd0);
      checkOutput("clrRamAddr", 32'(ram_addr), 32'd0);
      checkOutput("clrWdataReady", 32'(wdata_ready), 32'd0);
      checkOutput("clrRdata", rdata, 32'd0);
      checkOutput("clrRdataValid", 32'(rdata_valid), 32'd0);
      @(posedge clock); #1;
      clear = 1'b0; wdata_valid = 1'b0;
      @(negedge clock);
      checkOutput("clrIdleBusy", 32'(busy), 32'd0);
      checkOutput("clrIdleDone", 32'(done), 32'd0);
      rnd = '{we: 1'b0, addr: 9'd20, len: 4'd3, mask: 32'hFFFF_FFFF, dataBase: 32'h0, busyReq: 1'b0, expDone: 7};
      applyStimulus(rnd);

      for (int i = 0; i < 40; i++) begin
         rnd.we       = 1'($urandom_range(0, 1));
         rnd.addr     = ($urandom_range(0, 3) == 0) ? ADDR_W'(500 + $urandom_range(0, 11)) : ADDR_W'($urandom);
         rnd.len      = LEN_W'($urandom);
         rnd.mask     = $urandom | $urandom;
         rnd.dataBase = $urandom;
         rnd.busyReq  = 1'($urandom_range(0, 1));
         rnd.expDone  = 0;
         applyStimulus(rnd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

CPU-side memory controller that initiates all accesses to the 512 x 32 single-port `ram` block. It accepts a read or write request from the control unit and drives `ram`'s `read`, `write`, `addr` and `BusMuxOut` inputs. For reads it captures `MDataIn` after the RAM's one-cycle registered latency and returns it as `rdata`. Bursts of 1–16 consecutive words are supported, with address wrap-around.

## Interface
- `ADDR_W`, default 9: RAM word-address width.
- `DATA_W`, default 32: data width.
- `LEN_W`, default 4: burst-length field width (burst = `len` + 1 words).

Ports:
- `clock`  in  1  rising-edge clock.
- `clear`  in  1  reset; asynchronous, active-high.
- `req`  in  1  start request; sampled only in IDLE.
- `we`  in  1  1 = write burst, 0 = read burst; sampled with `req`.
- `start_addr`  in  ADDR_W  first word address; sampled with `req`.
- `len`  in  LEN_W  words minus 1; sampled with `req`.
- `busy`  out  1  high from the cycle after an accepted `req` through the DONE cycle.
- `wdata`  in  DATA_W  write beat data.
- `wdata_valid`  in  1  write beat offered.
- `wdata_ready`  out  1  controller accepts a beat this cycle.
- `rdata`  out  DATA_W  registered read data.
- `rdata_valid`  out  1  `rdata` holds a new word this cycle.
- `done`  out  1  one-cycle pulse when the burst completes.
- `ram_read`  out  1  to `ram` `read`.
- `ram_write`  out  1  to `ram` `write`.
- `ram_addr`  out  ADDR_W  to `ram` `addr`.
- `ram_wdata`  out  DATA_W  to `ram` `BusMuxOut`.
- `ram_rdata`  in  DATA_W  from `ram` `MDataIn`.

## Operation
- **States:** IDLE, RD_RUN, RD_DRAIN, WR_RUN, DONE.
- **Registers:** `cur_addr` (ADDR_W), `remaining` (LEN_W + 1), `cap_pipe` (2-bit valid shift), `rdata`.
- **IDLE:** on `req` = 1, latch `start_addr` into `cur_addr` and `len` + 1 into `remaining`.
  - Go to RD_RUN if `we` = 0, else WR_RUN.
  - `req` outside IDLE is ignored and has no queueing.
- **RD_RUN:** each cycle drive `ram_read` = 1 and `ram_addr` = `cur_addr`.
  - Increment `cur_addr`, decrement `remaining`, shift a 1 into `cap_pipe`.
  - When `remaining` reaches 0, go to RD_DRAIN.
- **Read capture:** when `cap_pipe[0]` = 1 (the cycle after an issue), register `rdata` ← `ram_rdata`. `rdata_valid` is the registered version of that capture.
  - Net effect: a word issued in cycle N appears on `rdata` with `rdata_valid` = 1 in cycle N+2.
- **RD_DRAIN:** `ram_read` = 0. Stay until `cap_pipe` is empty and the last `rdata_valid` has been presented, then go to DONE.
- **WR_RUN:** `wdata_ready` = 1.
  - On `wdata_valid` & `wdata_ready`, combinationally drive `ram_write` = 1, `ram_addr` = `cur_addr`, `ram_wdata` = `wdata`.
  - Then increment `cur_addr` and decrement `remaining`; go to DONE after the beat that brings `remaining` to 0.
  - A cycle with `wdata_valid` = 0 drives `ram_write` = 0 and leaves all state unchanged.
- **DONE:** `done` = 1 and `busy` = 1 for exactly one cycle, then IDLE.
- **Address arithmetic:** `cur_addr` increments modulo 2^ADDR_W, so 511 + 1 wraps to 0.
- **Exclusivity:** `ram_read` and `ram_write` are never high in the same cycle. Both are 0 outside RD_RUN and accepted write beats.
- **Idle outputs:** `ram_addr` and `ram_wdata` are 0 when idle. `rdata` holds its last value.
- **`clear` asserted:** immediately forces state IDLE and all outputs 0, including `ram_read`, `ram_write` and `rdata`. `cur_addr`, `remaining` and `cap_pipe` are cleared.
  - A burst interrupted by `clear` is abandoned and produces no `done`.
  - RAM contents already written are not rolled back.

## Timing
- **Read burst of L words:** `req` is sampled at the edge ending cycle 0.
  - Issues occur in cycles 1..L.
  - `rdata_valid` is high in cycles 3..L+2, back to back.
  - `done` fires in cycle L+3; `busy` is high in cycles 1..L+3; IDLE from cycle L+4.
  - Next `req` accepted in cycle L+4.
- **Write burst, no stalls:** beats are accepted in cycles 1..L, `done` fires in L+1, IDLE from L+2. Each stall cycle adds one cycle.
- **RAM read latency:** exactly one clock is assumed by design, matching the `ram` block.

## Test plan
- **Single write then single read:** write `0xDEADBEEF` to address 5 with `len` = 0, then read address 5 with `len` = 0.
  - Required: write beat in cycle 1, `done` in cycle 2.
  - Required: `rdata` = `0xDEADBEEF` with `rdata_valid` in cycle 3 of the read, `done` in cycle 4.
- **Wrap-around write:** write burst with `start_addr` = `0x1FE`, `len` = 3, data 1, 2, 3, 4.
  - Required: `ram_addr` sequence `0x1FE`, `0x1FF`, `0x000`, `0x001`.
  - Required: a following read burst over the same addresses returns 1, 2, 3, 4.
- **16-word read:** read burst with `len` = 15 from address 0, RAM preloaded with `mem[i]` = i + 100.
  - Required: `rdata_valid` high in cycles 3..18 with values 100..115, `done` in cycle 19.
  - Required: `ram_read` high only in cycles 1..16.
- **Write stalls:** write burst with `len` = 2, with `wdata_valid` dropped for 2 cycles between beats.
  - Required: `ram_write` high only on accepted beats; addresses advance only on those beats.
  - Required: `done` fires 1 cycle after the third beat.
- **Request while busy:** pulse `req` with `we` = 1 during an active read burst.
  - Required: the pulse is ignored; no `ram_write` occurs; the read burst completes normally.
- **Reset mid-burst:** assert `clear` in cycle 2 of a 4-word write burst.
  - Required: `ram_write`, `busy` and `done` go to 0 immediately; state is IDLE after release.
  - Required: only the beat(s) accepted before `clear` are present in RAM, and a new `req` is accepted normally.
